util_axis_word_to_hex: RTL
==========================

UTIL_AXIS_WORD_TO_HEX -- requirements
Module: util_axis_word_to_hex

Interface
REQ-001 SHALL have parameter word_bytes, default 4, meaning the number of bytes per input word (1 to 8).
REQ-002 SHALL have parameter uppercase, default 1: 1 selects hex digits A-F, 0 selects a-f.
REQ-003 SHALL have parameter add_crlf, default 1: 1 appends CR, LF after each word; 0 appends nothing.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port arstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_axis_tdata, input, word_bytes*8 bits: binary word to format.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: input word valid.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: block can accept a word.
REQ-009 SHALL have port m_axis_tdata, output, 8 bits: ASCII character to the downstream util_axis_uart s_axis.
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: character valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the character.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: marks the final character of each word.

Function
REQ-013 SHALL emit N = 2*word_bytes + (add_crlf ? 2 : 0) characters per accepted word.
REQ-014 SHALL emit hex digits most-significant nibble first.
REQ-015 SHALL map nibbles 0-9 to 0x30-0x39, and 10-15 to 0x41-0x46 (uppercase=1) or 0x61-0x66 (uppercase=0).
REQ-016 SHALL emit CR = 0x0D then LF = 0x0A when add_crlf=1.
REQ-017 SHALL assert m_axis_tlast only on the Nth character of a word.
REQ-018 SHALL use states IDLE, HEX, CR, LF: IDLE->HEX on input handshake; HEX->CR after the last nibble handshake (add_crlf=1); HEX->IDLE after the last nibble handshake (add_crlf=0); CR->LF on handshake; LF->IDLE on handshake.
REQ-019 SHALL drive s_axis_tready = arstn & (~m_axis_tvalid | (m_axis_tready & m_axis_tlast)).
REQ-020 SHALL go directly to HEX with the new word when a word is accepted in the same cycle as a tlast handshake, with no idle cycle between words.
REQ-021 SHALL present the first character of a word accepted at edge k as registered outputs after edge k, i.e. latency 1 cycle.
REQ-022 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 SHALL never deassert m_axis_tvalid mid-word; it clears only after a tlast handshake with no new word accepted.
REQ-024 SHALL use a nibble counter of width clog2(2*word_bytes) that counts down from 2*word_bytes-1 to 0, with no wrap.
REQ-025 SHALL latch the accepted word in an internal register and shift it left by 4 per hex handshake; s_axis_tdata is sampled only on the input handshake.

Reset
REQ-026 SHALL, while arstn=0, force m_axis_tvalid=0, m_axis_tdata=0x00, m_axis_tlast=0, s_axis_tready=0, state=IDLE, nibble counter=0 and word register=0.
REQ-027 SHALL discard any partially emitted word on reset assertion mid-word; after release, output resumes only with a newly accepted word.
REQ-028 SHALL synchronise arstn deassertion externally; the block does not synchronise it.

Structure
REQ-029 SHALL place in a shared package: the state enumeration, the ASCII_CR and ASCII_LF constants, and a nibble-to-ASCII function taking the uppercase selector.
REQ-030 SHALL be implemented as a single module with no sub-module, because the conversion is a package function.

Verification
REQ-031 SHALL cover the defaults with input 0x1234ABCD: output 31 32 33 34 41 42 43 44 0D 0A, tlast on 0A only, first char 1 cycle after the handshake.
REQ-032 SHALL cover uppercase=0, add_crlf=0 with input 0xDEADBEEF: output 64 65 61 64 62 65 65 66, tlast on the final 66.
REQ-033 SHALL cover back-to-back inputs 0x00000000 then 0xFFFFFFFF with m_axis_tready=1: 20 contiguous valid characters with no bubble, and the second word accepted on the first LF handshake.
REQ-034 SHALL cover random m_axis_tready (50%) over 100 random words: the output stream equals the reference model, and data is stable under stall.
REQ-035 SHALL cover arstn pulsed low after 3 characters of 0x1234ABCD: tvalid=0 immediately (asynchronously); the next word 0x0000000F yields 30 30 30 30 30 30 30 46 0D 0A.
REQ-036 SHALL cover the block driving util_axis_uart in loopback (4 Mbaud, 50 MHz): the UART m_axis receives 31 32 33 34 41 42 43 44 0D 0A in order.

Source files
------------

// File: rtl/util_axis_word_to_hex_pkg.sv
// Shared definitions for the AXI-Stream binary-word to ASCII-hex formatter:
// FSM states, line-ending characters and the nibble-to-ASCII mapping.
package util_axis_word_to_hex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEX  = 2'd1,
      ST_CR   = 2'd2,
      ST_LF   = 2'd3
   } state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic upper);
      logic [7:0] nib_w;
      nib_w = {4'h0, nib};
      if (nib < 4'd10) begin
         return 8'h30 + nib_w;
      end
      return (upper ? 8'h41 : 8'h61) + nib_w - 8'd10;
   endfunction

endpackage

// File: rtl/util_axis_word_to_hex.sv
// Formats each accepted binary word as ASCII hex (MS nibble first), optionally
// followed by CR LF, as a character stream with tlast on the final character.
module util_axis_word_to_hex
   import util_axis_word_to_hex_pkg::*;
#(
   parameter int word_bytes = 4,
   parameter bit uppercase  = 1'b1,
   parameter bit add_crlf   = 1'b1
) (
   input  logic                    aclk,
   input  logic                    arstn,
   input  logic [word_bytes*8-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast
);

   localparam int W     = word_bytes * 8;
   localparam int NIB   = 2 * word_bytes;
   localparam int CNT_W = $clog2(NIB);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NIB - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [W-1:0]     word_q,   word_d;
   logic [7:0]       tdata_q,  tdata_d;
   logic             tvalid_q, tvalid_d;
   logic             tlast_q,  tlast_d;

   logic             in_hs;
   logic             out_hs;
   logic [W-1:0]     shifted;

   // A new word may enter while idle or in the same cycle the final character leaves.
   assign s_axis_tready = arstn & (~tvalid_q | (m_axis_tready & tlast_q));
   assign in_hs         = s_axis_tvalid & s_axis_tready;
   assign out_hs        = tvalid_q & m_axis_tready;
   assign shifted       = word_q << 4;

   always_comb begin
      // NOTE: every next-state value gets a default first so no path infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;

      if (in_hs) begin
         state_d  = ST_HEX;
         cnt_d    = CNT_TOP;
         word_d   = s_axis_tdata;
         tdata_d  = nibble_to_ascii(s_axis_tdata[W-1 -: 4], uppercase);
         tvalid_d = 1'b1;
         tlast_d  = 1'b0;
      end else if (out_hs) begin
         unique case (state_q)
            ST_HEX: begin
               word_d = shifted;
               if (cnt_q != '0) begin
                  cnt_d   = cnt_q - CNT_ONE;
                  tdata_d = nibble_to_ascii(shifted[W-1 -: 4], uppercase);
                  tlast_d = !add_crlf && (cnt_q == CNT_ONE);
               end else if (add_crlf) begin
                  state_d = ST_CR;
                  tdata_d = ASCII_CR;
               end else begin
                  state_d  = ST_IDLE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
               end
            end
            ST_CR: begin
               state_d = ST_LF;
               tdata_d = ASCII_LF;
               tlast_d = 1'b1;
            end
            ST_LF: begin
               state_d  = ST_IDLE;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the word register is reset along with the control state, so a reset
   // mid-word leaves nothing behind to be emitted later.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         word_q   <= '0;
         tdata_q  <= 8'h00;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;

endmodule
